// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and memory-side signals of the arbiter.
// slave is the arbiter's view; master is the requester/memory view.
interface mem_arbiter_if;
  typedef logic [31:0] word_t;

  logic  iREN;
  word_t iaddr;
  logic  ihit;
  word_t iload;

  logic  dREN;
  logic  dWEN;
  logic  datomic;
  word_t daddr;
  word_t dstore;
  logic  dhit;
  word_t dload;

  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;
  logic  ramready;

  modport slave (
    input  iREN, iaddr,
    input  dREN, dWEN, datomic, daddr, dstore,
    input  ramload, ramready,
    output ihit, iload, dhit, dload,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr,
    output dREN, dWEN, datomic, daddr, dstore,
    output ramload, ramready,
    input  ihit, iload, dhit, dload,
    input  ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: one memory port shared by fetch and data, data first.
// Define MEM_ARBITER_ATOMIC_EN to add LL/SC link tracking.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
);

  localparam int CW =
    (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    DACC,
    IACC,
    SCFAIL
  } state_t;

  state_t        state;
  logic [CW-1:0] starveCnt;

  logic dReq;
  logic starved;
  logic dGrant;
  logic iGrant;
  logic scFail;

  assign dReq    = bus.dREN | bus.dWEN;
  assign starved = bus.iREN && (starveCnt == SMAX);
  assign dGrant  = dReq && !starved;
  assign iGrant  = bus.iREN && !dGrant;

`ifdef MEM_ARBITER_ATOMIC_EN
  logic [31:0] linkAddr;
  logic        linkValid;
  logic        isLl;
  logic        isSc;

  assign scFail = bus.dWEN && bus.datomic &&
    !(linkValid && (linkAddr == bus.daddr));
`else
  assign scFail = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      starveCnt    <= '0;
      bus.ihit     <= 1'b0;
      bus.dhit     <= 1'b0;
      bus.iload    <= '0;
      bus.dload    <= '0;
      bus.ramREN   <= 1'b0;
      bus.ramWEN   <= 1'b0;
      bus.ramaddr  <= '0;
      bus.ramstore <= '0;
`ifdef MEM_ARBITER_ATOMIC_EN
      linkAddr     <= '0;
      linkValid    <= 1'b0;
      isLl         <= 1'b0;
      isSc         <= 1'b0;
`endif
    end else begin
      bus.ihit <= 1'b0;
      bus.dhit <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            dGrant && scFail: begin
              state <= SCFAIL;
            end
            dGrant && !scFail: begin
              state        <= DACC;
              bus.ramWEN   <= bus.dWEN;
              bus.ramREN   <= !bus.dWEN;
              bus.ramaddr  <= bus.daddr;
              bus.ramstore <= bus.dstore;
              if (bus.iREN && (starveCnt != SMAX))
                starveCnt <= starveCnt + 1'b1;
`ifdef MEM_ARBITER_ATOMIC_EN
              isLl <= bus.dREN && !bus.dWEN &&
                bus.datomic;
              isSc <= bus.dWEN && bus.datomic;
`endif
            end
            iGrant: begin
              state       <= IACC;
              bus.ramREN  <= 1'b1;
              bus.ramWEN  <= 1'b0;
              bus.ramaddr <= bus.iaddr;
              starveCnt   <= '0;
            end
            default: ;
          endcase
        end
        DACC: begin
          if (bus.ramready) begin
            state      <= IDLE;
            bus.ramREN <= 1'b0;
            bus.ramWEN <= 1'b0;
            bus.dhit   <= 1'b1;
            bus.dload  <= bus.ramload;
`ifdef MEM_ARBITER_ATOMIC_EN
            if (isSc)
              bus.dload <= 32'd1;
            // any store to the linked word breaks the link
            if (bus.ramWEN && (bus.ramaddr == linkAddr))
              linkValid <= 1'b0;
            else if (isLl) begin
              linkAddr  <= bus.ramaddr;
              linkValid <= 1'b1;
            end
`endif
          end
        end
        IACC: begin
          if (bus.ramready) begin
            state      <= IDLE;
            bus.ramREN <= 1'b0;
            bus.ihit   <= 1'b1;
            bus.iload  <= bus.ramload;
          end
        end
        SCFAIL: begin
          state     <= IDLE;
          bus.dhit  <= 1'b1;
          bus.dload <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter
// against a memory model and transaction-level expectations.
module tb_mem_arbiter;
  localparam int SM = 4;

  logic CLK;
  logic RST;
  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(SM)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int fixLat = 1;
  logic [31:0] lastRamload = '0;
  logic [31:0] ramMem [logic [31:0]];
  logic [31:0] gold [logic [31:0]];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] initVal(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] ramRd(input logic [31:0] a);
    return ramMem.exists(a) ? ramMem[a] : initVal(a);
  endfunction

  function automatic logic [31:0] gRd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : initVal(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // memory device: answers after fixLat strobe cycles (0 = random)
  initial begin
    int busy;
    int curLat;
    busy = 0;
    curLat = 1;
    bus.ramready = 1'b0;
    bus.ramload = '0;
    forever begin
      @(negedge CLK);
      if (bus.ramREN || bus.ramWEN) begin
        if (busy == 0)
          curLat = (fixLat == 0) ? int'($urandom_range(1, 4)) : fixLat;
        busy++;
        if (busy >= curLat) begin
          bus.ramready = 1'b1;
          bus.ramload = bus.ramREN ? ramRd(bus.ramaddr) : $urandom;
          lastRamload = bus.ramload;
          if (bus.ramWEN) ramMem[bus.ramaddr] = bus.ramstore;
          busy = 0;
        end else begin
          bus.ramready = 1'b0;
        end
      end else begin
        busy = 0;
        bus.ramready = 1'b0;
      end
    end
  end

  task automatic doReset();
    bus.iREN = 0; bus.iaddr = '0;
    bus.dREN = 0; bus.dWEN = 0; bus.datomic = 0;
    bus.daddr = '0; bus.dstore = '0;
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic dataTx(input logic r, input logic w, input logic at,
                        input logic [31:0] a, input logic [31:0] s,
                        input bit drop, output logic [31:0] ld,
                        output int renC, output int wenC, output bit got);
    renC = 0; wenC = 0; got = 0; ld = '0;
    bus.dREN = r; bus.dWEN = w; bus.datomic = at;
    bus.daddr = a; bus.dstore = s;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge CLK);
      if (bus.ramREN) renC++;
      if (bus.ramWEN) wenC++;
      if (drop && (bus.ramREN || bus.ramWEN)) begin
        bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = 32'hFFFF_FFF0; bus.dstore = '0;
      end
      if (bus.dhit) begin
        got = 1;
        ld = bus.dload;
      end
    end
    bus.dREN = 0; bus.dWEN = 0; bus.datomic = 0;
  endtask

  initial begin
    int renC, wenC, hits, hitAt, seq, ov, k, nI, nD, dWhileI, r;
    bit got, seen, iPend, dPend, dIsW;
    logic [31:0] ld, il, dl, firstAddr, iA, dA, dS;

    doReset();
    chk("rst_ihit", {31'b0, bus.ihit}, 0);
    chk("rst_dhit", {31'b0, bus.dhit}, 0);
    chk("rst_ramREN", {31'b0, bus.ramREN}, 0);
    chk("rst_ramWEN", {31'b0, bus.ramWEN}, 0);
    chk("rst_iload", bus.iload, 0);
    chk("rst_dload", bus.dload, 0);
    chk("rst_ramaddr", bus.ramaddr, 0);
    chk("rst_ramstore", bus.ramstore, 0);

    // single fetch, memory answers on the third strobe cycle
    fixLat = 3;
    ramMem[32'h40] = 32'hDEAD_BEEF;
    bus.iREN = 1; bus.iaddr = 32'h40;
    renC = 0; hits = 0; hitAt = -1; il = '0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge CLK);
      if (bus.ramREN) renC++;
      if (bus.ihit) begin
        hits++;
        if (hitAt < 0) hitAt = c;
        il = bus.iload;
        bus.iREN = 0;
      end
    end
    chk("fetch_hits", 32'(hits), 1);
    chk("fetch_iload", il, 32'hDEAD_BEEF);
    chk("fetch_ramREN_cycles", 32'(renC), 3);
    chk("fetch_latency", 32'(hitAt), 4);

    doReset();
    chk("rst_clears_iload", bus.iload, 0);

    // simultaneous fetch and data read: data wins
    fixLat = 2;
    bus.iREN = 1; bus.iaddr = 32'h40;
    bus.dREN = 1; bus.daddr = 32'h100;
    seq = 0; ov = 0; seen = 0; firstAddr = '0; il = '0; dl = '0;
    for (int c = 0; c < 40 && seq < 10; c++) begin
      @(negedge CLK);
      if (!seen && (bus.ramREN || bus.ramWEN)) begin
        seen = 1;
        firstAddr = bus.ramaddr;
      end
      if (bus.ihit && bus.dhit) ov++;
      if (bus.dhit) begin seq = seq * 10 + 1; dl = bus.dload; bus.dREN = 0; end
      if (bus.ihit) begin seq = seq * 10 + 2; il = bus.iload; bus.iREN = 0; end
    end
    chk("prio_first_addr", firstAddr, 32'h100);
    chk("prio_order", 32'(seq), 12);
    chk("prio_overlap", 32'(ov), 0);
    chk("prio_dload", dl, initVal(32'h100));
    chk("prio_iload", il, 32'hDEAD_BEEF);

    // held fetch vs back-to-back writes: fetch after STARVE_MAX writes
    doReset();
    fixLat = 1;
    bus.iREN = 1; bus.iaddr = 32'h44;
    bus.dWEN = 1; bus.daddr = 32'h180; bus.dstore = 32'hC0DE_0000;
    k = 0; seq = 0;
    for (int c = 0; c < 80 && seq < 1000000; c++) begin
      @(negedge CLK);
      if (bus.dhit) begin
        seq = seq * 10 + 1;
        k++;
        if (k < 6) begin
          bus.daddr = 32'h180 + 32'(k) * 4;
          bus.dstore = 32'hC0DE_0000 + 32'(k);
        end else begin
          bus.dWEN = 0;
        end
      end
      if (bus.ihit) begin seq = seq * 10 + 2; bus.iREN = 0; end
    end
    chk("starve_order", 32'(seq), 1111211);
    chk("starve_wr0", ramRd(32'h180), 32'hC0DE_0000);
    chk("starve_wr5", ramRd(32'h194), 32'hC0DE_0005);

    // reset in the middle of a stalled write
    doReset();
    fixLat = 100;
    bus.dWEN = 1; bus.daddr = 32'h300; bus.dstore = 32'h1;
    @(negedge CLK);
    @(negedge CLK);
    chk("midrst_wen_before", {31'b0, bus.ramWEN}, 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_wen_after", {31'b0, bus.ramWEN}, 0);
    chk("midrst_dhit", {31'b0, bus.dhit}, 0);
    RST = 1'b0; bus.dWEN = 0;
    hits = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      if (bus.dhit || bus.ramWEN) hits++;
    end
    chk("midrst_quiet", 32'(hits), 0);
    chk("midrst_no_write", {31'b0, ramMem.exists(32'h300)}, 0);
    fixLat = 1;
    bus.iREN = 1; bus.iaddr = 32'h40;
    hitAt = -1;
    for (int c = 1; c <= 10 && hitAt < 0; c++) begin
      @(negedge CLK);
      if (bus.ihit) begin hitAt = c; bus.iREN = 0; end
    end
    chk("midrst_idle_latency", 32'(hitAt), 2);

    // request dropped right after grant still completes
    fixLat = 3;
    dataTx(1, 0, 0, 32'h140, '0, 1, ld, renC, wenC, got);
    chk("drop_got", {31'b0, got}, 1);
    chk("drop_dload", ld, initVal(32'h140));
    chk("drop_ren_cycles", 32'(renC), 3);
    @(negedge CLK);
    chk("idle_ramaddr_hold", bus.ramaddr, 32'h140);
    chk("idle_ramREN", {31'b0, bus.ramREN}, 0);

    // read+write together is a write
    fixLat = 1;
    dataTx(1, 1, 0, 32'h150, 32'h1234_5678, 0, ld, renC, wenC, got);
    chk("rw_got", {31'b0, got}, 1);
    chk("rw_no_read", 32'(renC), 0);
    chk("rw_mem", ramRd(32'h150), 32'h1234_5678);

`ifdef MEM_ARBITER_ATOMIC_EN
    dataTx(1, 0, 1, 32'h200, '0, 0, ld, renC, wenC, got);
    chk("ll_dload", ld, ramRd(32'h200));
    dataTx(0, 1, 1, 32'h200, 32'h77, 0, ld, renC, wenC, got);
    chk("sc_ok_dload", ld, 1);
    chk("sc_ok_wrote", {31'b0, wenC > 0}, 1);
    chk("sc_ok_mem", ramRd(32'h200), 32'h77);
    dataTx(0, 1, 1, 32'h200, 32'h88, 0, ld, renC, wenC, got);
    chk("sc_again_got", {31'b0, got}, 1);
    chk("sc_again_dload", ld, 0);
    chk("sc_again_nowen", 32'(wenC), 0);
    chk("sc_again_mem", ramRd(32'h200), 32'h77);
    dataTx(1, 0, 1, 32'h200, '0, 0, ld, renC, wenC, got);
    dataTx(0, 1, 0, 32'h200, 32'h99, 0, ld, renC, wenC, got);
    dataTx(0, 1, 1, 32'h200, 32'hAA, 0, ld, renC, wenC, got);
    chk("sc_broken_dload", ld, 0);
    chk("sc_broken_nowen", 32'(wenC), 0);
    chk("sc_broken_mem", ramRd(32'h200), 32'h99);
`else
    dataTx(0, 1, 1, 32'h160, 32'hAB, 0, ld, renC, wenC, got);
    chk("sc_plain_got", {31'b0, got}, 1);
    chk("sc_plain_dload", ld, lastRamload);
    chk("sc_plain_mem", ramRd(32'h160), 32'hAB);
`endif

    // randomized traffic against a transaction-level memory model
    doReset();
    fixLat = 0;
    nI = 0; nD = 0; dWhileI = 0;
    iPend = 0; dPend = 0; dIsW = 0;
    iA = '0; dA = '0; dS = '0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge CLK);
      chk("rand_overlap", {31'b0, bus.ihit & bus.dhit}, 0);
      if (bus.ihit) begin
        chk("rand_ihit_expected", {31'b0, iPend}, 1);
        if (iPend) chk("rand_iload", bus.iload, gRd(iA));
        iPend = 0; bus.iREN = 0; nI++;
      end
      if (bus.dhit) begin
        chk("rand_dhit_expected", {31'b0, dPend}, 1);
        if (dPend && dIsW) gold[dA] = dS;
        else if (dPend) chk("rand_dload", bus.dload, gRd(dA));
        if (iPend) begin
          dWhileI++;
          chk("rand_starve", {31'b0, dWhileI > SM + 1}, 0);
        end
        dPend = 0; bus.dREN = 0; bus.dWEN = 0; nD++;
      end
      if (!iPend && nI < 100 && $urandom_range(0, 3) == 0) begin
        iPend = 1; dWhileI = 0;
        iA = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
        bus.iREN = 1; bus.iaddr = iA;
      end
      if (!dPend && nD < 150 && $urandom_range(0, 1) == 0) begin
        r = int'($urandom_range(0, 2));
        dPend = 1; dIsW = (r != 0);
        dA = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
        dS = $urandom;
        bus.dREN = (r != 1); bus.dWEN = (r != 0);
        bus.daddr = dA; bus.dstore = dS;
      end
      if (nI == 100 && nD == 150 && !iPend && !dPend) break;
    end
    chk("rand_fetch_count", 32'(nI), 100);
    chk("rand_data_count", 32'(nD), 150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
